// File: rtl/rop_logic_sched_if.sv
// Fragment, memory and logic-op unit signals of the ROP logic-op sequencer.
// The master modport is the sequencer; the slave modport is its environment.
interface rop_logic_sched_if #(
    parameter int ADDRW = 32
);
    logic             req_valid;
    logic             req_ready;
    logic [ADDRW-1:0] req_addr;
    logic [31:0]      req_color;
    logic [3:0]       req_mask;
    logic [3:0]       req_op;

    logic             mem_rd_valid;
    logic             mem_rd_ready;
    logic [ADDRW-1:0] mem_rd_addr;
    logic             mem_rsp_valid;
    logic [31:0]      mem_rsp_data;

    logic             lop_enable;
    logic [3:0]       lop_op;
    logic [31:0]      lop_src;
    logic [31:0]      lop_dst;
    logic [31:0]      lop_color;

    logic             mem_wr_valid;
    logic             mem_wr_ready;
    logic [ADDRW-1:0] mem_wr_addr;
    logic [31:0]      mem_wr_data;
    logic [3:0]       mem_wr_byteen;

    modport master (
        input  req_valid, req_addr, req_color, req_mask, req_op,
        output req_ready,
        output mem_rd_valid, mem_rd_addr,
        input  mem_rd_ready, mem_rsp_valid, mem_rsp_data,
        output lop_enable, lop_op, lop_src, lop_dst,
        input  lop_color,
        output mem_wr_valid, mem_wr_addr, mem_wr_data, mem_wr_byteen,
        input  mem_wr_ready
    );

    modport slave (
        output req_valid, req_addr, req_color, req_mask, req_op,
        input  req_ready,
        input  mem_rd_valid, mem_rd_addr,
        output mem_rd_ready, mem_rsp_valid, mem_rsp_data,
        input  lop_enable, lop_op, lop_src, lop_dst,
        output lop_color,
        input  mem_wr_valid, mem_wr_addr, mem_wr_data, mem_wr_byteen,
        output mem_wr_ready
    );
endinterface

// File: rtl/rop_logic_sched.sv
// ROP logic-op sequencer: accepts one fragment, optionally reads the destination,
// runs the logic-op unit for LATENCY cycles and writes the masked result back.
//
// state      | meaning
// -----------+------------------------------------------------------------
// ST_IDLE    | ready for a fragment; skip fragments retire here directly
// ST_RD_REQ  | destination read request outstanding
// ST_RD_WAIT | read accepted, waiting for response data
// ST_EXEC    | logic-op unit enabled, LATENCY cycles
// ST_WR      | write-back request outstanding
module rop_logic_sched #(
    parameter int ADDRW   = 32,
    parameter int LATENCY = 1
) (
    input  logic              clk,
    input  logic              reset,
    rop_logic_sched_if.master bus,
    output logic              busy,
    output logic [31:0]       frag_count,
    output logic              err
);
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_REQ,
        ST_RD_WAIT,
        ST_EXEC,
        ST_WR
    } state_t;

    localparam logic [3:0] OP_CLEAR    = 4'd0;
    localparam logic [3:0] OP_COPY     = 4'd3;
    localparam logic [3:0] OP_NOOP     = 4'd5;
    localparam logic [3:0] OP_COPY_INV = 4'd12;
    localparam logic [3:0] OP_SET      = 4'd15;
    localparam logic [2:0] EXEC_LAST   = 3'(LATENCY - 1);

    state_t           state_q, state_d;
    logic [ADDRW-1:0] addr_q, addr_d;
    logic [31:0]      color_q, color_d;
    logic [31:0]      dst_q, dst_d;
    logic [3:0]       op_q, op_d;
    logic [3:0]       mask_q, mask_d;
    logic [2:0]       cnt_q, cnt_d;
    logic [31:0]      frag_count_q, frag_count_d;
    logic             err_q, err_d;

    logic accept;
    logic skip;
    logic no_read;

    assign accept  = bus.req_valid && (state_q == ST_IDLE);
    assign skip    = (bus.req_mask == 4'd0) || (bus.req_op == OP_NOOP);
    assign no_read = (bus.req_op == OP_CLEAR) || (bus.req_op == OP_COPY) ||
                     (bus.req_op == OP_COPY_INV) || (bus.req_op == OP_SET);

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        color_d      = color_q;
        dst_d        = dst_q;
        op_d         = op_q;
        mask_d       = mask_q;
        cnt_d        = cnt_q;
        frag_count_d = frag_count_q;
        err_d        = err_q;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (skip) begin
                        frag_count_d = frag_count_q + 32'd1;
                    end else begin
                        addr_d  = bus.req_addr;
                        color_d = bus.req_color;
                        op_d    = bus.req_op;
                        mask_d  = bus.req_mask;
                        dst_d   = 32'd0;
                        cnt_d   = 3'd0;
                        state_d = no_read ? ST_EXEC : ST_RD_REQ;
                    end
                end
            end
            ST_RD_REQ: begin
                if (bus.mem_rd_ready) begin
                    state_d = ST_RD_WAIT;
                end
            end
            ST_RD_WAIT: begin
                if (bus.mem_rsp_valid) begin
                    dst_d   = bus.mem_rsp_data;
                    cnt_d   = 3'd0;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (cnt_q == EXEC_LAST) begin
                    state_d = ST_WR;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            ST_WR: begin
                if (bus.mem_wr_ready) begin
                    frag_count_d = frag_count_q + 32'd1;
                    state_d      = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Responses are only expected while waiting for one; anything else is sticky.
        if (bus.mem_rsp_valid && (state_q != ST_RD_WAIT)) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            addr_q       <= '0;
            color_q      <= '0;
            dst_q        <= '0;
            op_q         <= '0;
            mask_q       <= '0;
            cnt_q        <= '0;
            frag_count_q <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            color_q      <= color_d;
            dst_q        <= dst_d;
            op_q         <= op_d;
            mask_q       <= mask_d;
            cnt_q        <= cnt_d;
            frag_count_q <= frag_count_d;
            err_q        <= err_d;
        end
    end

    assign bus.req_ready     = (state_q == ST_IDLE);
    assign bus.mem_rd_valid  = (state_q == ST_RD_REQ);
    assign bus.mem_rd_addr   = addr_q;
    assign bus.lop_enable    = (state_q == ST_EXEC);
    assign bus.lop_op        = op_q;
    assign bus.lop_src       = color_q;
    assign bus.lop_dst       = dst_q;
    assign bus.mem_wr_valid  = (state_q == ST_WR);
    assign bus.mem_wr_addr   = addr_q;
    assign bus.mem_wr_data   = bus.lop_color;
    assign bus.mem_wr_byteen = mask_q;

    assign busy       = (state_q != ST_IDLE);
    assign frag_count = frag_count_q;
    assign err        = err_q;
endmodule
